// File: rtl/uart_rx_byte_latch.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) that latches each good byte
// on data_out for the LCD character input and flags bad frames with single-cycle pulses.
module uart_rx_byte_latch #(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] IDLE_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_out_reg, data_out_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             parity_ok;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_reg, par_bit_next;
    logic             parity_err_reg, parity_err_next;
`endif

    assign rx_s = sync_reg[1];

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones across data+parity even.
    assign parity_ok = (par_bit_reg == ^shift_reg);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b11;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= IDLE_CHAR;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            sync_reg       <= {sync_reg[0], rx};
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= par_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next    = par_bit_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: a line that has gone high again was only a glitch.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    par_bit_next = rx_s;
                    state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK;
                    end else if (parity_ok) begin
                        data_out_next   = shift_reg;
                        byte_valid_next = 1'b1;
                        state_next      = ST_IDLE;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err_next = 1'b1;
`endif
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign data_out   = data_out_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte_latch.sv
// Self-checking bench for uart_rx_byte_latch: directed scenarios plus random frames
// judged against a frame-level model of what each serial frame should produce.
module tb_uart_rx_byte_latch;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       byte_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_byte_latch #(
        .CLKS_PER_BIT(CPB),
        .IDLE_CHAR   (8'h20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         bv_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         bv_times[$];
    logic       rst_prev = 1'b1;
    logic [7:0] dout_prev = 8'h20;
    logic [7:0] exp_data = 8'h20;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse monitor; also enforces that data_out only moves on a byte_valid cycle.
    always @(negedge clk) begin
        if (!rst && !rst_prev) begin
            if (byte_valid) begin
                bv_cnt++;
                bv_times.push_back(cyc);
            end
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (data_out !== dout_prev) check_val("dout_change_needs_valid", 32'(byte_valid), 32'd1);
            if (int'(byte_valid) + int'(frame_err) + int'(parity_err) > 1)
                check_val("single_pulse", 32'(int'(byte_valid) + int'(frame_err) + int'(parity_err)), 32'd1);
        end
        rst_prev  = rst;
        dout_prev = data_out;
    end

    // Called and returns at posedge+1.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int hold);
        int   bv0 = bv_cnt;
        int   fe0 = fe_cnt;
        int   pe0 = pe_cnt;
        int   start;
        int   lat;
        bit   par_eff;
        bit   exp_bv;
        logic pbit;
        pbit = par_ok ? ^d : ~^d;
`ifdef UART_RX_PARITY_EN
        par_eff = par_ok;
`else
        par_eff = 1'b1;
`endif
        exp_bv = stop_ok && par_eff;
        start  = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop_ok);
        if (!stop_ok) begin
            repeat (hold) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        if (exp_bv) exp_data = d;
        check_val("byte_valid_count", 32'(bv_cnt - bv0), 32'(exp_bv));
        check_val("frame_err_count", 32'(fe_cnt - fe0), 32'(!stop_ok));
        check_val("parity_err_count", 32'(pe_cnt - pe0), 32'(stop_ok && !par_eff));
        check_val("data_out", 32'(data_out), 32'(exp_data));
        check_val("busy_after_frame", 32'(busy), 32'd0);
        if (exp_bv && bv_times.size() > 0) begin
            // Stop-bit centre plus synchroniser and output register, with a little slack.
            lat = bv_times[$] - start;
            check_val("latency_window",
                      32'(lat >= (NBITS - 1) * CPB + CPB / 2 && lat <= (NBITS - 1) * CPB + CPB / 2 + 5),
                      32'd1);
        end
        $display("frame data=%02h stop_ok=%0d par_ok=%0d bv=%0d fe=%0d pe=%0d data_out=%02h",
                 d, stop_ok, par_ok, bv_cnt - bv0, fe_cnt - fe0, pe_cnt - pe0, data_out);
    endtask

    initial begin
        int   bv0;
        int   fe0;
        int   pe0;
        bit   saw_busy;
        logic [7:0] d;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("reset_data_out", 32'(data_out), 32'h20);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_pulses", 32'({byte_valid, frame_err, parity_err}), 32'd0);

        bv0 = bv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        saw_busy = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        check_val("idle_no_busy", 32'(saw_busy), 32'd0);
        check_val("idle_no_pulses", 32'((bv_cnt - bv0) + (fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
        $display("idle 100 cycles busy_seen=%0d", saw_busy);

        run_frame(8'h41, 1'b1, 1'b1, 0);

        bv0 = bv_times.size();
        run_frame(8'h55, 1'b1, 1'b1, 0);
        run_frame(8'hAA, 1'b1, 1'b1, 0);
        if (bv_times.size() >= bv0 + 2)
            check_val("back_to_back_spacing", 32'(bv_times[$] - bv_times[$-1]), 32'(NBITS * CPB));
        else
            check_val("back_to_back_pulses", 32'(bv_times.size() - bv0), 32'd2);

        bv0 = bv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        saw_busy = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        check_val("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check_val("glitch_busy_cleared", 32'(busy), 32'd0);
        check_val("glitch_no_pulses", 32'((bv_cnt - bv0) + (fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
        check_val("glitch_data_out", 32'(data_out), 32'(exp_data));
        $display("glitch 4 cycles busy_seen=%0d data_out=%02h", saw_busy, data_out);

        run_frame(8'h33, 1'b0, 1'b1, 50);
        run_frame(8'h31, 1'b1, 1'b1, 0);

`ifdef UART_RX_PARITY_EN
        run_frame(8'h07, 1'b1, 1'b0, 0);
        run_frame(8'h07, 1'b1, 1'b1, 0);
`endif

        d = 8'($urandom_range(0, 255));
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        exp_data = 8'h20;
        check_val("midframe_rst_data_out", 32'(data_out), 32'h20);
        check_val("midframe_rst_busy", 32'(busy), 32'd0);
        check_val("midframe_rst_pulses", 32'({byte_valid, frame_err, parity_err}), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_val("midframe_rst_idle", 32'(busy), 32'd0);
        $display("reset mid-frame partial=%02h data_out=%02h", d, data_out);
        run_frame(8'h5A, 1'b1, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0,
                      $urandom_range(0, 3) != 0, int'($urandom_range(0, 30)));
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
